// File: rtl/factorial_inverse.sv
// Factorial inverse: searches n in 0..MAX_N with n! == VALUE using an iterative
// multiply/compare datapath behind a GO/DONE level handshake.
module factorial_inverse #(
  parameter int unsigned MAX_N = 12,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         GO,
  input  logic [W-1:0] VALUE,
  output logic         DONE,
  output logic         FOUND,
  output logic [3:0]   N_OUT,
  output logic [3:0]   debugcs
);

  localparam int unsigned PW    = W + 4;
  localparam logic [3:0]  MAX_K = 4'(MAX_N);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_CMP  = 4'd2,
    S_MUL  = 4'd3,
    S_DONE = 4'd4
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] val_q, val_d;
  logic [3:0]   k_q, k_d;
  logic [3:0]   n_d;
  logic         found_d, done_d;
  logic [3:0]   k_inc_c;
  logic [W-1:0] mul_c;

  assign k_inc_c = k_q + 4'd1;
  // Product is formed W+4 wide; acc is bounded by MAX_N! so the low W bits are exact.
  assign mul_c   = W'(PW'(acc_q) * PW'(k_inc_c));
  assign debugcs = state_q;

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    val_d   = val_q;
    k_d     = k_q;
    found_d = FOUND;
    n_d     = N_OUT;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (GO) state_d = S_LOAD;
      end
      S_LOAD: begin
        val_d   = VALUE;
        acc_d   = W'(1);
        k_d     = 4'd0;
        found_d = 1'b0;
        n_d     = 4'd0;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (acc_q == val_q) begin
          found_d = 1'b1;
          n_d     = k_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if ((acc_q > val_q) || (k_q == MAX_K)) begin
          found_d = 1'b0;
          n_d     = 4'd0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        k_d     = k_inc_c;
        acc_d   = mul_c;
        state_d = S_CMP;
      end
      S_DONE: begin
        if (GO) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= W'(1);
      val_q   <= '0;
      k_q     <= 4'd0;
      DONE    <= 1'b0;
      FOUND   <= 1'b0;
      N_OUT   <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      k_q     <= k_d;
      DONE    <= done_d;
      FOUND   <= found_d;
      N_OUT   <= n_d;
    end
  end

endmodule
